// File: rtl/display_pkg.sv
// Constants shared by the 7-segment display drivers.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return HEX_SEG[nib];
   endfunction

endpackage

// File: rtl/hex_seg_encode.sv
// Combinational hex nibble to active-low segment encoder; 'minus' overrides
// the nibble with a lone segment g.
module hex_seg_encode
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       minus,
   output logic [6:0] seg
);

   always_comb begin
      seg = hex_to_seg(nibble);
      if (minus) begin
         seg = SEG_MINUS;
      end
   end

endmodule

// File: rtl/scan_display_n.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with per-digit
// enable, leading-zero blanking, PWM brightness and per-frame input snapshot.
module scan_display_n
   import display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned TICK_DIV    = 10000,
   parameter int unsigned BRIGHT_BITS = 3
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [4*NUM_DIGITS-1:0]  digits,
   input  logic [NUM_DIGITS-1:0]    decPts,
   input  logic [NUM_DIGITS-1:0]    signs,
   input  logic [NUM_DIGITS-1:0]    digitEn,
   input  logic                     lzBlank,
   input  logic [BRIGHT_BITS-1:0]   brightness,
   output logic [6:0]               segs,
   output logic                     DP,
   output logic [NUM_DIGITS-1:0]    anodes,
   output logic                     frameStart
);

   localparam int unsigned PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned SUB_DIV = TICK_DIV >> BRIGHT_BITS;

   logic [PRE_W-1:0]         pre_q, pre_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]  sh_digits_q, sh_digits_d;
   logic [NUM_DIGITS-1:0]    sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]    sh_sign_q, sh_sign_d;
   logic [NUM_DIGITS-1:0]    sh_en_q, sh_en_d;
   logic                     sh_lz_q, sh_lz_d;
   logic [BRIGHT_BITS-1:0]   sh_bright_q, sh_bright_d;
   logic [6:0]               segs_q, segs_d;
   logic                     dp_q, dp_d;
   logic [NUM_DIGITS-1:0]    anodes_q, anodes_d;

   logic                     snap;
   logic [NUM_DIGITS-1:0]    blank;
   logic                     scanning;
   logic [3:0]               cur_nib;
   logic [31:0]              sub;
   logic                     lit;

   assign snap       = (pre_q == '0) && (idx_q == '0);
   assign frameStart = snap & ~Reset;

   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = idx_q;
      if (pre_q == PRE_W'(TICK_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // The slot being output during the snapshot cycle already sees the new
   // inputs, so the shadow next-state doubles as the effective frame view.
   always_comb begin
      sh_digits_d = sh_digits_q;
      sh_dp_d     = sh_dp_q;
      sh_sign_d   = sh_sign_q;
      sh_en_d     = sh_en_q;
      sh_lz_d     = sh_lz_q;
      sh_bright_d = sh_bright_q;
      if (snap) begin
         sh_digits_d = digits;
         sh_dp_d     = decPts;
         sh_sign_d   = signs;
         sh_en_d     = digitEn;
         sh_lz_d     = lzBlank;
         sh_bright_d = brightness;
      end
   end

   always_comb begin
      blank    = '0;
      scanning = sh_lz_d;
      for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
         if (scanning && (sh_digits_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0) &&
             !sh_sign_d[NUM_DIGITS-1-k] && !sh_dp_d[NUM_DIGITS-1-k]) begin
            blank[NUM_DIGITS-1-k] = 1'b1;
         end else begin
            scanning = 1'b0;
         end
      end
   end

   assign cur_nib = sh_digits_d[4*idx_q +: 4];

   hex_seg_encode u_enc (
      .nibble (cur_nib),
      .minus  (sh_sign_d[idx_q]),
      .seg    (segs_d)
   );

   always_comb begin
      sub      = 32'(pre_q) / SUB_DIV;
      lit      = (sub < 32'(sh_bright_d)) && sh_en_d[idx_q] && !blank[idx_q];
      dp_d     = ~sh_dp_d[idx_q];
      anodes_d = '1;
      if (lit) begin
         anodes_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pre_q       <= '0;
         idx_q       <= '0;
         sh_digits_q <= '0;
         sh_dp_q     <= '0;
         sh_sign_q   <= '0;
         sh_en_q     <= '0;
         sh_lz_q     <= 1'b0;
         sh_bright_q <= '0;
         segs_q      <= SEG_BLANK;
         dp_q        <= 1'b1;
         anodes_q    <= '1;
      end else begin
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         sh_digits_q <= sh_digits_d;
         sh_dp_q     <= sh_dp_d;
         sh_sign_q   <= sh_sign_d;
         sh_en_q     <= sh_en_d;
         sh_lz_q     <= sh_lz_d;
         sh_bright_q <= sh_bright_d;
         segs_q      <= segs_d;
         dp_q        <= dp_d;
         anodes_q    <= anodes_d;
      end
   end

   assign segs   = segs_q;
   assign DP     = dp_q;
   assign anodes = anodes_q;

endmodule

// File: tb/tb_scan_display_n.sv
// Scoreboard bench for scan_display_n: a cycle model predicts the pins,
// directed checks cover the frame/blanking/brightness scenarios.
module tb_scan_display_n;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [15:0] digits;
   logic [3:0]  decPts, signs, digitEn;
   logic        lzBlank;
   logic [1:0]  brightness;
   logic [6:0]  segs;
   logic        DP;
   logic [3:0]  anodes;
   logic        frameStart;

   scan_display_n #(.NUM_DIGITS(4), .TICK_DIV(16), .BRIGHT_BITS(2)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .digits     (digits),
      .decPts     (decPts),
      .signs      (signs),
      .digitEn    (digitEn),
      .lzBlank    (lzBlank),
      .brightness (brightness),
      .segs       (segs),
      .DP         (DP),
      .anodes     (anodes),
      .frameStart (frameStart)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] sg;
      logic       dp;
   } pins_t;

   pins_t       sb_q[$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          scen    = 0;
   bit          counting = 1'b0;
   int          lowcnt[4];
   logic [6:0]  lastseg[4];

   // reference model state
   int          m_pre = 0, m_idx = 0;
   logic [15:0] m_dg = '0;
   logic [3:0]  m_dp = '0, m_sn = '0, m_en = '0;
   logic        m_lz = 1'b0;
   logic [1:0]  m_br = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   function automatic pins_t model_pins();
      pins_t       p;
      logic [15:0] dg;
      logic [3:0]  dpv, sn, en, nib;
      logic        lz;
      logic [1:0]  br;
      int          top;
      p.an = 4'hF; p.sg = 7'h7F; p.dp = 1'b1;
      if (Reset) return p;
      if (m_pre == 0 && m_idx == 0) begin
         dg = digits; dpv = decPts; sn = signs; en = digitEn; lz = lzBlank; br = brightness;
      end else begin
         dg = m_dg; dpv = m_dp; sn = m_sn; en = m_en; lz = m_lz; br = m_br;
      end
      top = 0;
      for (int i = 1; i < 4; i++)
         if (dg[4*i +: 4] != 4'h0 || sn[i] || dpv[i]) top = i;
      nib  = dg[4*m_idx +: 4];
      p.sg = sn[m_idx] ? 7'b0111111 : ref_seg(nib);
      p.dp = ~dpv[m_idx];
      if ((m_pre / 4) < int'(br) && en[m_idx] && !(lz && m_idx > top)) p.an[m_idx] = 1'b0;
      return p;
   endfunction

   task automatic model_advance();
      if (Reset) begin
         m_pre = 0; m_idx = 0; m_dg = '0; m_dp = '0; m_sn = '0; m_en = '0; m_lz = 1'b0; m_br = '0;
      end else begin
         if (m_pre == 0 && m_idx == 0) begin
            m_dg = digits; m_dp = decPts; m_sn = signs; m_en = digitEn; m_lz = lzBlank; m_br = brightness;
         end
         m_pre++;
         if (m_pre == 16) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 4;
         end
      end
   endtask

   task automatic tick();
      pins_t e;
      sb_q.push_back(model_pins());
      @(posedge CLK);
      model_advance();
      cyc++;
      #1;
      e = sb_q.pop_front();
      chk("anodes", anodes, e.an);
      chk("segs", segs, e.sg);
      chk("dp", DP, e.dp);
      chk("frameStart", frameStart, (!Reset && m_pre == 0 && m_idx == 0));
      chk("onecold", ($countones(~anodes) <= 1), 1);
      if (scen == 1) begin
         if (cyc % 64 == 0) chk("fs_period", frameStart, 1);
         if (cyc >= 1 && cyc <= 12) begin
            chk("s0_an", anodes, 4'b1110);
            chk("s0_seg", segs, 7'b0001110);
         end
         if (cyc >= 13 && cyc <= 16) chk("s0_off", anodes, 4'hF);
         if (cyc >= 49 && cyc <= 60) begin
            chk("s3_an", anodes, 4'b0111);
            chk("s3_seg", segs, 7'b1111001);
         end
      end
      if (counting)
         for (int i = 0; i < 4; i++)
            if (anodes[i] == 1'b0) begin
               lowcnt[i]++;
               lastseg[i] = segs;
            end
   endtask

   task automatic sync_frame();
      int guard = 0;
      while (frameStart !== 1'b1 && guard < 200) begin
         tick();
         guard++;
      end
      chk("sync_frame", frameStart, 1);
   endtask

   task automatic count_frame();
      for (int i = 0; i < 4; i++) begin
         lowcnt[i]  = 0;
         lastseg[i] = 7'h7F;
      end
      sync_frame();
      counting = 1'b1;
      repeat (64) tick();
      counting = 1'b0;
   endtask

   task automatic expect_counts(input int c3, input int c2, input int c1, input int c0);
      chk("low3", lowcnt[3], c3);
      chk("low2", lowcnt[2], c2);
      chk("low1", lowcnt[1], c1);
      chk("low0", lowcnt[0], c0);
   endtask

   initial begin
      Reset = 1'b1;
      digits = 16'h12AF; decPts = 4'h0; signs = 4'h0; digitEn = 4'hF;
      lzBlank = 1'b0; brightness = 2'd3;
      repeat (3) tick();
      chk("rst_an", anodes, 4'hF);
      chk("rst_seg", segs, 7'h7F);

      Reset = 1'b0;
      cyc   = 0;
      scen  = 1;
      #1;
      chk("fs_first", frameStart, 1);
      repeat (128) tick();
      scen = 0;

      lzBlank = 1'b1; digits = 16'h0070;
      count_frame();
      expect_counts(0, 0, 12, 12);
      chk("lz_seg1", lastseg[1], 7'b1111000);
      chk("lz_seg0", lastseg[0], 7'b1000000);

      digits = 16'h0000;
      count_frame();
      expect_counts(0, 0, 0, 12);
      chk("zero_seg0", lastseg[0], 7'b1000000);

      signs = 4'b0100;
      count_frame();
      expect_counts(0, 12, 12, 12);
      chk("minus_seg2", lastseg[2], 7'b0111111);
      chk("minus_seg1", lastseg[1], 7'b1000000);

      signs = 4'h0; lzBlank = 1'b0; digits = 16'h12AF; brightness = 2'd1;
      count_frame();
      expect_counts(4, 4, 4, 4);

      brightness = 2'd0;
      count_frame();
      expect_counts(0, 0, 0, 0);

      brightness = 2'd3; digitEn = 4'b1011;
      count_frame();
      expect_counts(12, 0, 12, 12);

      digitEn = 4'hF;
      count_frame();
      sync_frame();
      repeat (20) tick();
      digits = 16'h3456;
      tick();
      chk("mid_hold_seg", segs, 7'b0001000);
      chk("mid_hold_an", anodes, 4'b1101);
      sync_frame();
      chk("mid_old_seg", segs, 7'b1111001);
      tick();
      chk("mid_new_seg", segs, 7'b0000010);
      chk("mid_new_an", anodes, 4'b1110);

      repeat (36) tick();
      Reset = 1'b1;
      tick();
      chk("mr_an", anodes, 4'hF);
      chk("mr_seg", segs, 7'h7F);
      chk("mr_dp", DP, 1);
      Reset = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/scan_display_n.md
# scan_display_n

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It is the successor to the fixed four-digit scanner, adding:
- configurable digit count and scan rate;
- per-digit enable;
- leading-zero blanking;
- PWM brightness;
- frame-coherent input snapshotting.

It sits between lab datapath logic and the board's segment/anode pins, and has a single system clock.

## Interface
- NUM_DIGITS, 4, digits scanned; anodes[i] drives digit i, i=0 rightmost.
- TICK_DIV, 10000, CLK cycles per digit slot; must be a multiple of 2**BRIGHT_BITS, ≥ 2**BRIGHT_BITS.
- BRIGHT_BITS, 3, brightness resolution.
- CLK  in  1  system clock; sole clock.
- Reset  in  1  synchronous, active-high reset.
- digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4i+3:4i].
- decPts  in  NUM_DIGITS  1 = light DP of digit i.
- signs  in  NUM_DIGITS  1 = show '-' (segment g only) instead of nibble on digit i.
- digitEn  in  NUM_DIGITS  0 = digit i anode never driven.
- lzBlank  in  1  1 = blank leading zeros.
- brightness  in  BRIGHT_BITS  0 = dark, 2**BRIGHT_BITS-1 = brightest.
- segs  out  7  active-low {g,f,e,d,c,b,a}.
- DP  out  1  active-low decimal point.
- anodes  out  NUM_DIGITS  active-low digit enables; at most one low at any time.
- frameStart  out  1  one-cycle pulse when the input snapshot is taken.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 and wraps. Slot index `idx` increments when `pre` wraps, and wraps at NUM_DIGITS-1 → 0.
- Snapshot: when pre==0 and idx==0:
  - digits, decPts, signs, digitEn, lzBlank and brightness are registered into shadow copies;
  - frameStart=1 in that cycle.
  - All display decisions for the frame use only the shadow copies, so mid-frame input changes are not visible until the next frame.
- Leading-zero mask, computed from the snapshot:
  - Scanning from digit NUM_DIGITS-1 downward, digit i (i>0) is blanked while its nibble==0, signs[i]==0 and decPts[i]==0.
  - Blanking stops at the first digit failing that test. Digit 0 is never blanked.
  - Blanked digits keep their anode off.
- Segment source for the current idx:
  - signs → 7'b0111111;
  - otherwise the hex encoding: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.
  - DP = ~decPts[idx].
- PWM: sub = pre / (TICK_DIV >> BRIGHT_BITS), range 0..2**BRIGHT_BITS-1. anodes[idx] is driven low only when all three hold:
  - sub < brightness;
  - digitEn[idx]==1;
  - the digit is not blanked.
  - All other anodes are high.
- A dark slot still emits valid segs/DP; only the anode is suppressed.

## Timing
- Outputs segs, DP and anodes are registered, with 1-cycle latency from (pre, idx) to the pins.
- Frame period is NUM_DIGITS*TICK_DIV cycles. A snapshot change appears on the pins no earlier than the cycle after the next frameStart, plus 1.
- Reset (any cycle, including mid-frame):
  - pre=0, idx=0;
  - shadow registers cleared (brightness=0, digitEn=0);
  - anodes all 1, segs=7'h7F, DP=1, frameStart=0.
- First cycle after Reset deasserts: pre=0 and idx=0, so frameStart=1 and the snapshot loads. The first lit anode is possible 1 cycle after that.
- Slot boundary: the anode for idx goes high on the same output edge at which the anode for idx+1 may go low. Because sub restarts at 0 each slot, no two anodes are ever low together.
- brightness = 2**BRIGHT_BITS-1 gives a duty of (2**BRIGHT_BITS-1)/2**BRIGHT_BITS. The guaranteed off subslot at the end of each slot doubles as anti-ghosting blanking.

## Structure
- Shared package display_pkg:
  - SEG_BLANK = 7'h7F, SEG_MINUS = 7'b0111111;
  - the 16-entry hex-to-segment constant table.
- One combinational sub-module, hex_seg_encode (nibble, minus → seg[6:0]), reused by other display blocks.
- Prescaler, scan index, snapshot, LZ mask and output registers live in scan_display_n.

## Test plan
All scenarios use NUM_DIGITS=4, TICK_DIV=16, BRIGHT_BITS=2.
- Reset then digits=16'h12AF, digitEn=4'hF, brightness=3, lzBlank=0:
  - frameStart at cycle 0 after reset and every 64 cycles;
  - anodes=1110 with segs=0001110 for cycles 1–12 of slot 0, then 1111 for cycles 13–16;
  - slot 3 shows anodes=0111, segs=1111001.
- lzBlank=1, digits=16'h0070, decPts=0: digits 3 and 2 anodes never low; digits 1 and 0 light ('7', '0').
- lzBlank=1, digits=16'h0000: only digit 0 lights ('0'). Then signs=4'b0100: digit 2 shows '-', digit 1 shows '0', digit 3 is blank.
- brightness=1: each lit anode is low exactly 4 of 16 cycles. brightness=0: anodes stay 4'hF for a full frame.
- Change digits mid-frame (cycle 20): pins unchanged until the cycle after the next frameStart, plus 1. Assert Reset at cycle 37: the next edge gives anodes=4'hF, segs=7'h7F, DP=1.
- Continuous check on every cycle: anodes has at most one zero bit, and digitEn=4'b1011 never drives anodes[2] low.
